// File: rtl/e_mdu_ctrl_pkg.sv
// rtl/e_mdu_ctrl_pkg.sv - shared MDU op encodings, latencies and helpers
package e_mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    function automatic logic is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// rtl/e_mdu_ctrl_if.sv - E-stage to MDU request/readback bundle
// Signals: start, md_op, rd_hi, A, B (requester -> MDU);
//          busy, stall_req, HI, LO, rdata (MDU -> requester).
interface e_mdu_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic        rd_hi;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] rdata;

    modport master (
        output start, md_op, rd_hi, A, B,
        input  busy, stall_req, HI, LO, rdata
    );

    modport slave (
        input  start, md_op, rd_hi, A, B,
        output busy, stall_req, HI, LO, rdata
    );
endinterface

// File: rtl/e_mdu_ctrl_arith.sv
// rtl/e_mdu_ctrl_arith.sv - combinational product/quotient/remainder (module mdu_arith)
// Ports: op (md_op), a, b operands; res_hi/res_lo result words;
//        div_zero flags a divide op with b == 0 (result must not commit).
// Divider logic exists only when MDU_DIV_EN is defined.
module mdu_arith
    import e_mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    // Sign-extend to 64 bits so the truncated unsigned product is the
    // exact two's-complement signed product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
    logic        sgn;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] den_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_out;
    logic [31:0] r_out;

    // Signed division works on magnitudes, then fixes signs: the quotient
    // truncates toward zero and the remainder follows the dividend.
    assign sgn      = (op == MD_DIV);
    assign num      = (sgn && a[31]) ? -a : a;
    assign den      = (sgn && b[31]) ? -b : b;
    assign den_safe = (b == 32'd0) ? 32'd1 : den;
    assign q_mag    = num / den_safe;
    assign r_mag    = num % den_safe;
    assign q_out    = (sgn && (a[31] ^ b[31])) ? -q_mag : q_mag;
    assign r_out    = (sgn && a[31]) ? -r_mag : r_mag;
`endif

    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        div_zero = 1'b0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
`ifdef MDU_DIV_EN
            MD_DIV, MD_DIVU: begin
                res_lo   = q_out;
                res_hi   = r_out;
                div_zero = (b == 32'd0);
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// rtl/e_mdu_ctrl.sv - E-stage multiply/divide unit control with HI/LO registers
// Ports: clk, reset (sync, active-high); bus (e_mdu_ctrl_if.slave):
//        start/md_op/rd_hi/A/B in, busy/stall_req/HI/LO/rdata out.
// Config: MDU_DIV_EN enables DIV/DIVU; otherwise they are no-ops.
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    e_mdu_ctrl_if.slave  bus
);

    state_e      state;
    state_e      state_nxt;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_skip;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;

    logic        req_mul;
    logic        req_div;
    logic        accept_mul;
    logic        accept_div;

    mdu_arith u_arith (
        .op       (bus.md_op),
        .a        (bus.A),
        .b        (bus.B),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign req_mul = bus.start && is_mul(bus.md_op);
`ifdef MDU_DIV_EN
    assign req_div = bus.start && is_div(bus.md_op);
`else
    assign req_div = 1'b0;
`endif

    assign accept_mul = (state == ST_IDLE) && req_mul;
    assign accept_div = (state == ST_IDLE) && req_div;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept_mul || accept_div) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt == 4'd1) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_skip <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) begin
                if (accept_mul || accept_div) begin
                    pend_hi   <= res_hi;
                    pend_lo   <= res_lo;
                    // Divide-by-zero still occupies the unit but never commits.
                    pend_skip <= div_zero;
                    cnt       <= accept_mul ? MULT_CNT : DIV_CNT;
                end else if (bus.start && bus.md_op == MD_MTHI) begin
                    hi_q <= bus.A;
                end else if (bus.start && bus.md_op == MD_MTLO) begin
                    lo_q <= bus.A;
                end
            end else begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1 && !pend_skip) begin
                    hi_q <= pend_hi;
                    lo_q <= pend_lo;
                end
            end
        end
    end

    assign bus.busy      = (state == ST_BUSY);
    assign bus.stall_req = bus.busy || req_mul || req_div;
    assign bus.HI        = hi_q;
    assign bus.LO        = lo_q;
    assign bus.rdata     = bus.rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// tb/tb_e_mdu_ctrl.sv - self-checking bench for e_mdu_ctrl
module tb_e_mdu_ctrl;
    import e_mdu_ctrl_pkg::*;

    logic clk;
    logic reset;

    e_mdu_ctrl_if bus_i ();

    e_mdu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One-cycle request starting at a falling edge; returns at the next falling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        bus_i.start = 1'b1;
        bus_i.md_op = op;
        bus_i.A     = a;
        @(negedge clk);
        bus_i.start = 1'b0;
        bus_i.md_op = MD_NONE;
    endtask

    task automatic preload();
        issue(MD_MTHI, 32'h11);
        issue(MD_MTLO, 32'h22);
    endtask

    initial begin
        int nbusy;
        int guard;
        n_checks = 0;
        n_fail   = 0;
        reset        = 1'b1;
        bus_i.start  = 1'b0;
        bus_i.md_op  = MD_NONE;
        bus_i.rd_hi  = 1'b0;
        bus_i.A      = 32'd0;
        bus_i.B      = 32'd0;

        vecs.push_back('{"mult_neg1x2",  MD_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5});
        vecs.push_back('{"multu_maxx2",  MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5});
        vecs.push_back('{"mult_pos",     MD_MULT,  32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 5});
        vecs.push_back('{"multu_2p62",   MD_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5});
        vecs.push_back('{"mult_m3x5",    MD_MULT,  32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5});
`ifdef MDU_DIV_EN
        vecs.push_back('{"div_m7d2",     MD_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
        vecs.push_back('{"divu_7d2",     MD_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, 10});
        vecs.push_back('{"div_7dm2",     MD_DIV,   32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10});
        vecs.push_back('{"div_by0",      MD_DIV,   32'd5, 32'd0, 32'h11, 32'h22, 10});
`else
        vecs.push_back('{"div_off",      MD_DIV,   32'hFFFFFFF9, 32'd2, 32'h11, 32'h22, 0});
        vecs.push_back('{"divu_off",     MD_DIVU,  32'd7, 32'd2, 32'h11, 32'h22, 0});
`endif
        vecs.push_back('{"mtlo_1234",    MD_MTLO,  32'h1234, 32'd0, 32'h11, 32'h1234, 0});
        vecs.push_back('{"mthi_beef",    MD_MTHI,  32'hBEEF, 32'd0, 32'hBEEF, 32'h22, 0});
        vecs.push_back('{"none_nop",     MD_NONE,  32'h5555, 32'd3, 32'h11, 32'h22, 0});

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_hi", bus_i.HI, 32'd0);
        check("reset_lo", bus_i.LO, 32'd0);
        check("reset_busy", {31'd0, bus_i.busy}, 32'd0);
        check("reset_stall", {31'd0, bus_i.stall_req}, 32'd0);

        foreach (vecs[i]) begin
            preload();
            bus_i.start = 1'b1;
            bus_i.md_op = vecs[i].op;
            bus_i.A     = vecs[i].a;
            bus_i.B     = vecs[i].b;
            bus_i.rd_hi = 1'b0;
            #1;
            check({vecs[i].name, "_stall"}, {31'd0, bus_i.stall_req}, {31'd0, vecs[i].lat != 0});
            @(negedge clk);
            bus_i.start = 1'b0;
            bus_i.md_op = MD_NONE;
            #1;
            if (vecs[i].lat != 0)
                check({vecs[i].name, "_rdata_old"}, bus_i.rdata, 32'h22);
            nbusy = 0;
            guard = 0;
            while (bus_i.busy && guard < 40) begin
                nbusy++;
                guard++;
                @(negedge clk);
                #1;
            end
            check({vecs[i].name, "_busy_cycles"}, nbusy, vecs[i].lat);
            check({vecs[i].name, "_hi"}, bus_i.HI, vecs[i].hi);
            check({vecs[i].name, "_lo"}, bus_i.LO, vecs[i].lo);
            bus_i.rd_hi = 1'b1;
            #1;
            check({vecs[i].name, "_rdata_hi"}, bus_i.rdata, vecs[i].hi);
            bus_i.rd_hi = 1'b0;
            #1;
            check({vecs[i].name, "_rdata_lo"}, bus_i.rdata, vecs[i].lo);
        end

        // MTHI presented while a multiply is in flight must be ignored.
        preload();
        bus_i.start = 1'b1;
        bus_i.md_op = MD_MULT;
        bus_i.A     = 32'hFFFFFFFF;
        bus_i.B     = 32'd2;
        @(negedge clk);
        bus_i.md_op = MD_MTHI;
        bus_i.A     = 32'hAAAA;
        #1;
        check("busy_mthi_stall", {31'd0, bus_i.stall_req}, 32'd1);
        guard = 0;
        while (bus_i.busy && guard < 40) begin
            guard++;
            @(negedge clk);
            #1;
        end
        check("busy_mthi_hi", bus_i.HI, 32'hFFFFFFFF);
        check("busy_mthi_lo", bus_i.LO, 32'hFFFFFFFE);
        bus_i.start = 1'b0;
        bus_i.md_op = MD_NONE;

        // Reset on the third busy cycle aborts the multiply.
        preload();
        bus_i.start = 1'b1;
        bus_i.md_op = MD_MULT;
        bus_i.A     = 32'hFFFFFFFF;
        bus_i.B     = 32'd2;
        @(negedge clk);
        bus_i.start = 1'b0;
        bus_i.md_op = MD_NONE;
        repeat (2) @(negedge clk);
        #1;
        check("abort_busy_c3", {31'd0, bus_i.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus_i.busy}, 32'd0);
        check("abort_hi", bus_i.HI, 32'd0);
        check("abort_lo", bus_i.LO, 32'd0);
        repeat (8) @(negedge clk);
        #1;
        check("abort_late_hi", bus_i.HI, 32'd0);
        check("abort_late_lo", bus_i.LO, 32'd0);
        check("abort_late_busy", {31'd0, bus_i.busy}, 32'd0);

        // Reset wins over a simultaneous MTHI.
        @(negedge clk);
        reset       = 1'b1;
        bus_i.start = 1'b1;
        bus_i.md_op = MD_MTHI;
        bus_i.A     = 32'h5A5A;
        @(negedge clk);
        reset       = 1'b0;
        bus_i.start = 1'b0;
        bus_i.md_op = MD_NONE;
        #1;
        check("reset_over_mthi", bus_i.HI, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
